// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : conv_pkg
// Description : Shared types, default geometry and width helper for the
//               input-reuse convolution sequencer, datapath and bench.
// Revision    : 1.0 - initial release
// ============================================================================
package conv_pkg;

    // Default geometry shared by the sequencer, the datapath and the bench
    localparam int CONV_KERNELS    = 3;
    localparam int CONV_ROWS       = 3;
    localparam int CONV_COLS       = 3;
    localparam int CONV_IMAGE_ROWS = 28;
    localparam int CONV_IMAGE_COLS = 28;

    // Sequencer states
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_DRAIN = 3'd2,
        S_EMIT  = 3'd3,
        S_DONE  = 3'd4
    } conv_seq_state_t;

    // Counter width for a count of 'value' states; never narrower than 1 bit
    function automatic int clog2_min1(input int value);
        return (value <= 1) ? 1 : $clog2(value);
    endfunction

endpackage
`default_nettype wire

// File: rtl/conv_window_counter.sv
`default_nettype none
// ============================================================================
// Module      : conv_window_counter
// Description : Nested tap / window-column / window-row counters with wrap
//               and last flags consumed by the sequencer FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_window_counter
    import conv_pkg::*;
#(
    parameter int  COLS     = CONV_COLS,
    parameter int  TAPS     = CONV_ROWS * CONV_COLS,
    parameter int  OUT_ROWS = CONV_IMAGE_ROWS - CONV_ROWS + 1,
    parameter int  OUT_COLS = CONV_IMAGE_COLS - CONV_COLS + 1,
    localparam int TW       = clog2_min1(TAPS),
    localparam int JW       = clog2_min1(COLS),
    localparam int ORW      = clog2_min1(OUT_ROWS),
    localparam int OCW      = clog2_min1(OUT_COLS)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clr_i,
    input  logic           tap_adv_i,
    input  logic           win_adv_i,
    output logic [TW-1:0]  tap_o,
    output logic [ORW-1:0] win_r_o,
    output logic [OCW-1:0] win_c_o,
    output logic           tap_last_o,
    output logic           j_last_o,
    output logic           win_c_last_o,
    output logic           win_last_o
);

    logic [TW-1:0]  tap_q;
    logic [JW-1:0]  j_q;
    logic [ORW-1:0] win_r_q;
    logic [OCW-1:0] win_c_q;

    assign tap_o        = tap_q;
    assign win_r_o      = win_r_q;
    assign win_c_o      = win_c_q;
    assign tap_last_o   = (tap_q == TW'(TAPS - 1));
    assign j_last_o     = (j_q == JW'(COLS - 1));
    assign win_c_last_o = (win_c_q == OCW'(OUT_COLS - 1));
    assign win_last_o   = win_c_last_o && (win_r_q == ORW'(OUT_ROWS - 1));

    // Tap and kernel-column count wrap together after the last tap; the
    // window position advances raster order, column fastest
    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            tap_q   <= '0;
            j_q     <= '0;
            win_r_q <= '0;
            win_c_q <= '0;
        end else begin
            if (tap_adv_i) begin
                tap_q <= tap_last_o ? '0 : tap_q + 1'b1;
                j_q   <= j_last_o   ? '0 : j_q + 1'b1;
            end
            if (win_adv_i) begin
                if (win_c_last_o) begin
                    win_c_q <= '0;
                    win_r_q <= win_r_q + 1'b1;
                end else begin
                    win_c_q <= win_c_q + 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/conv_reuse_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : conv_reuse_sequencer
// Description : FSM controller for the input-reuse convolution datapath.
//               Fetches each window pixel once per tap, broadcasts it to all
//               kernel lanes, then emits the per-kernel results over
//               valid/ready. Start/done handshake brackets a run.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_reuse_sequencer
    import conv_pkg::*;
#(
    parameter int  KERNELS    = CONV_KERNELS,
    parameter int  ROWS       = CONV_ROWS,
    parameter int  COLS       = CONV_COLS,
    parameter int  IMAGE_ROWS = CONV_IMAGE_ROWS,
    parameter int  IMAGE_COLS = CONV_IMAGE_COLS,
    localparam int OUT_ROWS   = IMAGE_ROWS - ROWS + 1,
    localparam int OUT_COLS   = IMAGE_COLS - COLS + 1,
    localparam int TAPS       = ROWS * COLS,
    localparam int RW         = clog2_min1(IMAGE_ROWS),
    localparam int CW         = clog2_min1(IMAGE_COLS),
    localparam int TW         = clog2_min1(TAPS),
    localparam int KW         = clog2_min1(KERNELS),
    localparam int ORW        = clog2_min1(OUT_ROWS),
    localparam int OCW        = clog2_min1(OUT_COLS)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    output logic           done,
    output logic           busy,
    output logic           img_rd_en,
    output logic [RW-1:0]  img_row,
    output logic [CW-1:0]  img_col,
    output logic           mac_en,
    output logic           mac_first,
    output logic [TW-1:0]  tap_idx,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [KW-1:0]  out_kernel,
    output logic [ORW-1:0] out_row,
    output logic [OCW-1:0] out_col
);

    conv_seq_state_t state_q;
    logic            start_q;
    logic            done_q, busy_q, rd_en_q, mac_en_q, mac_first_q, out_valid_q;
    logic [RW-1:0]   img_row_q;
    logic [CW-1:0]   img_col_q;
    logic [TW-1:0]   tap_idx_q;
    logic [KW-1:0]   out_kernel_q;
    logic [ORW-1:0]  out_row_q;
    logic [OCW-1:0]  out_col_q;

    logic [TW-1:0]   cnt_tap;
    logic [ORW-1:0]  cnt_win_r;
    logic [OCW-1:0]  cnt_win_c;
    logic            tap_last, j_last, win_c_last, win_last;

    logic            start_edge, idle_like, kernel_last, emit_last;
    logic            cnt_clr, tap_adv, win_adv;
    logic [RW-1:0]   next_org_row;
    logic [CW-1:0]   next_org_col;

    assign start_edge   = start && !start_q;
    assign idle_like    = (state_q == S_IDLE) || (state_q == S_DONE);
    assign kernel_last  = (out_kernel_q == KW'(KERNELS - 1));
    assign emit_last    = (state_q == S_EMIT) && out_ready && kernel_last;
    assign cnt_clr      = idle_like && start_edge;
    assign tap_adv      = (state_q == S_FETCH);
    assign win_adv      = emit_last && !win_last;

    // Origin of the window that follows the current one (first read address)
    assign next_org_row = win_c_last ? RW'(cnt_win_r) + 1'b1 : RW'(cnt_win_r);
    assign next_org_col = win_c_last ? '0 : CW'(cnt_win_c) + 1'b1;

    conv_window_counter #(
        .COLS     (COLS),
        .TAPS     (TAPS),
        .OUT_ROWS (OUT_ROWS),
        .OUT_COLS (OUT_COLS)
    ) u_win_cnt (
        .clk          (clk),
        .rst          (rst),
        .clr_i        (cnt_clr),
        .tap_adv_i    (tap_adv),
        .win_adv_i    (win_adv),
        .tap_o        (cnt_tap),
        .win_r_o      (cnt_win_r),
        .win_c_o      (cnt_win_c),
        .tap_last_o   (tap_last),
        .j_last_o     (j_last),
        .win_c_last_o (win_c_last),
        .win_last_o   (win_last)
    );

    // Sequencer FSM; every output is a register so the address and MAC
    // strobes leave the block glitch-free. mac_* defaults low each cycle and
    // is set only in the cycle after a read, which makes it the read
    // strobe delayed by one.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            start_q      <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            rd_en_q      <= 1'b0;
            img_row_q    <= '0;
            img_col_q    <= '0;
            mac_en_q     <= 1'b0;
            mac_first_q  <= 1'b0;
            tap_idx_q    <= '0;
            out_valid_q  <= 1'b0;
            out_kernel_q <= '0;
            out_row_q    <= '0;
            out_col_q    <= '0;
        end else begin
            start_q     <= start;
            mac_en_q    <= 1'b0;
            mac_first_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_edge) begin
                        state_q   <= S_FETCH;
                        done_q    <= 1'b0;
                        busy_q    <= 1'b1;
                        rd_en_q   <= 1'b1;
                        img_row_q <= '0;
                        img_col_q <= '0;
                    end
                end
                S_FETCH: begin
                    mac_en_q    <= 1'b1;
                    mac_first_q <= (cnt_tap == '0);
                    tap_idx_q   <= cnt_tap;
                    if (tap_last) begin
                        rd_en_q <= 1'b0;
                        state_q <= S_DRAIN;
                    end else if (j_last) begin
                        img_row_q <= img_row_q + 1'b1;
                        img_col_q <= CW'(cnt_win_c);
                    end else begin
                        img_col_q <= img_col_q + 1'b1;
                    end
                end
                S_DRAIN: begin
                    state_q      <= S_EMIT;
                    out_valid_q  <= 1'b1;
                    out_kernel_q <= '0;
                    out_row_q    <= cnt_win_r;
                    out_col_q    <= cnt_win_c;
                end
                S_EMIT: begin
                    if (out_ready) begin
                        if (kernel_last) begin
                            out_valid_q <= 1'b0;
                            if (win_last) begin
                                state_q <= S_DONE;
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                            end else begin
                                state_q   <= S_FETCH;
                                rd_en_q   <= 1'b1;
                                img_row_q <= next_org_row;
                                img_col_q <= next_org_col;
                            end
                        end else begin
                            out_kernel_q <= out_kernel_q + 1'b1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign done       = done_q;
    assign busy       = busy_q;
    assign img_rd_en  = rd_en_q;
    assign img_row    = img_row_q;
    assign img_col    = img_col_q;
    assign mac_en     = mac_en_q;
    assign mac_first  = mac_first_q;
    assign tap_idx    = tap_idx_q;
    assign out_valid  = out_valid_q;
    assign out_kernel = out_kernel_q;
    assign out_row    = out_row_q;
    assign out_col    = out_col_q;

endmodule
`default_nettype wire

// File: tb/tb_conv_reuse_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_reuse_sequencer
// Description : Self-checking bench for conv_reuse_sequencer. Read, MAC and
//               handshake streams are compared against sequences computed
//               arithmetically from the scan order (window-major, tap-minor).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_reuse_sequencer;
    import conv_pkg::*;

    localparam int TAPS  = CONV_ROWS * CONV_COLS;
    localparam int OR_N  = CONV_IMAGE_ROWS - CONV_ROWS + 1;
    localparam int OC_N  = CONV_IMAGE_COLS - CONV_COLS + 1;
    localparam int NWIN  = OR_N * OC_N;
    localparam int RW    = clog2_min1(CONV_IMAGE_ROWS);
    localparam int CW    = clog2_min1(CONV_IMAGE_COLS);
    localparam int TW    = clog2_min1(TAPS);
    localparam int KW    = clog2_min1(CONV_KERNELS);
    localparam int ORW   = clog2_min1(OR_N);
    localparam int OCW   = clog2_min1(OC_N);

    logic           clk = 1'b0;
    logic           rst, start, out_ready;
    logic           done, busy, img_rd_en, mac_en, mac_first, out_valid;
    logic [RW-1:0]  img_row;
    logic [CW-1:0]  img_col;
    logic [TW-1:0]  tap_idx;
    logic [KW-1:0]  out_kernel;
    logic [ORW-1:0] out_row;
    logic [OCW-1:0] out_col;

    conv_reuse_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .done       (done),
        .busy       (busy),
        .img_rd_en  (img_rd_en),
        .img_row    (img_row),
        .img_col    (img_col),
        .mac_en     (mac_en),
        .mac_first  (mac_first),
        .tap_idx    (tap_idx),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_kernel (out_kernel),
        .out_row    (out_row),
        .out_col    (out_col)
    );

    always #5 clk = ~clk;

    int vectors, miscompares, cyc;
    // reference-model progress through the expected streams of one run
    int rd_n, mac_n, hs_n, start_cyc, first_rd_cyc;
    int last_rd_row, last_rd_col, last_hs_row, last_hs_col, wrap_row, wrap_col;
    logic prev_rd, stalled;
    logic [31:0] h_k, h_r, h_c;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check_zero(input string tag);
        chk(tag, {done, busy, img_rd_en, mac_en, mac_first, out_valid,
                  img_row, img_col, tap_idx, out_kernel, out_row, out_col}, 32'd0);
    endtask

    function automatic logic pick_ready(input int mode, input int n);
        case (mode)
            0:       return 1'b1;
            1:       return ((n % 4) == 0) || ((n % 4) == 3);
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    task automatic begin_run();
        rd_n = 0; mac_n = 0; hs_n = 0; prev_rd = 1'b0; stalled = 1'b0;
        first_rd_cyc = -1;
        start = 1'b1;
        start_cyc = cyc;
    endtask

    // Compare one cycle of DUT activity against the expected streams:
    // read n is tap n%TAPS of window n/TAPS, windows raster over OR_N x OC_N;
    // handshake n is kernel n%KERNELS of window n/KERNELS.
    task automatic monitor();
        int w, t;
        chk("mac_en_follows_rd", mac_en, prev_rd);
        if (mac_en) begin
            chk("tap_idx", tap_idx, mac_n % TAPS);
            chk("mac_first", mac_first, (mac_n % TAPS) == 0);
            mac_n++;
        end
        if (img_rd_en) begin
            w = rd_n / TAPS;
            t = rd_n % TAPS;
            chk("rd_row", img_row, w / OC_N + t / CONV_COLS);
            chk("rd_col", img_col, w % OC_N + t % CONV_COLS);
            chk("rd_during_emit", out_valid, 1'b0);
            if (rd_n == 0) begin
                chk("first_rd_latency", cyc, start_cyc + 1);
                first_rd_cyc = cyc;
            end
            if (rd_n == OC_N * TAPS) begin
                wrap_row = img_row;
                wrap_col = img_col;
            end
            last_rd_row = img_row;
            last_rd_col = img_col;
            rd_n++;
        end
        if (stalled) begin
            chk("stall_valid", out_valid, 1'b1);
            chk("stall_kernel", out_kernel, h_k);
            chk("stall_row", out_row, h_r);
            chk("stall_col", out_col, h_c);
        end
        if (out_valid && out_ready) begin
            w = hs_n / CONV_KERNELS;
            chk("hs_kernel", out_kernel, hs_n % CONV_KERNELS);
            chk("hs_row", out_row, w / OC_N);
            chk("hs_col", out_col, w % OC_N);
            last_hs_row = out_row;
            last_hs_col = out_col;
            hs_n++;
        end
        stalled = out_valid && !out_ready;
        h_k = out_kernel; h_r = out_row; h_c = out_col;
        chk("busy_vs_done", busy, !done);
        prev_rd = img_rd_en;
    endtask

    // Step until done rises, stop_rd reads have been seen, or budget expires
    task automatic run(input int mode, input bit hold, input int stop_rd, input int budget);
        int n = 0;
        forever begin
            tick();
            if (!hold) start = 1'b0;
            out_ready = pick_ready(mode, n);
            if (n == 0) chk("done_falls_on_start", done, 1'b0);
            monitor();
            if (done) begin
                if (mode == 0) chk("done_latency", cyc - first_rd_cyc, 8788);
                break;
            end
            if (stop_rd != 0 && rd_n >= stop_rd) break;
            n++;
            if (n >= budget) begin
                chk("run_timeout_done", done, 1'b1);
                break;
            end
        end
    endtask

    task automatic check_full_run(input string tag);
        chk({tag, "_handshakes"}, hs_n, NWIN * CONV_KERNELS);
        chk({tag, "_reads"}, rd_n, NWIN * TAPS);
        chk({tag, "_macs"}, mac_n, NWIN * TAPS);
        chk({tag, "_last_rd_row"}, last_rd_row, CONV_IMAGE_ROWS - 1);
        chk({tag, "_last_rd_col"}, last_rd_col, CONV_IMAGE_COLS - 1);
        chk({tag, "_last_win_row"}, last_hs_row, OR_N - 1);
        chk({tag, "_last_win_col"}, last_hs_col, OC_N - 1);
        chk({tag, "_done"}, done, 1'b1);
        chk({tag, "_busy"}, busy, 1'b0);
    endtask

    task automatic idle_gap();
        repeat ($urandom_range(1, 4)) begin
            tick();
            chk("idle_no_read", img_rd_en, 1'b0);
        end
    endtask

    initial begin
        vectors = 0; miscompares = 0; cyc = 0;
        rst = 1'b1; start = 1'b0; out_ready = 1'b1;
        wrap_row = -1; wrap_col = -1;

        // reset, then a 2-cycle reset pulse while idle
        repeat (3) tick();
        check_zero("reset_init");
        rst = 1'b0;
        repeat (4) tick();
        check_zero("idle_after_reset");
        rst = 1'b1;
        tick();
        tick();
        check_zero("reset_mid_idle");
        rst = 1'b0;
        tick();
        check_zero("idle_post_reset");

        // full run, out_ready always high; includes wrap from (0,25) to (1,0)
        idle_gap();
        begin_run();
        run(0, 1'b0, 0, 9200);
        check_full_run("full");
        chk("wrap_first_rd_row", wrap_row, 1);
        chk("wrap_first_rd_col", wrap_col, 0);

        // backpressure 1,0,0,1 with start held high for the whole run
        idle_gap();
        begin_run();
        run(1, 1'b1, 0, 20000);
        check_full_run("bp");

        // held start must not retrigger; a fresh edge restarts
        repeat (16) begin
            tick();
            chk("held_done", done, 1'b1);
            chk("held_busy", busy, 1'b0);
            chk("held_no_read", img_rd_en, 1'b0);
        end
        start = 1'b0;
        tick();
        chk("start_low_done", done, 1'b1);
        begin_run();
        run(2, 1'b0, 0, 30000);
        check_full_run("rand");

        // reset during window (10,5), then restart from (0,0)
        idle_gap();
        begin_run();
        run(0, 1'b0, (10 * OC_N + 5) * TAPS + 1, 9200);
        chk("mid_rd_row", last_rd_row, 10);
        chk("mid_rd_col", last_rd_col, 5);
        chk("mid_handshakes", hs_n, (10 * OC_N + 5) * CONV_KERNELS);
        rst = 1'b1;
        tick();
        check_zero("reset_mid_run");
        rst = 1'b0;
        tick();
        check_zero("idle_after_mid_reset");
        idle_gap();
        begin_run();
        run(0, 1'b0, TAPS, 100);
        chk("restart_reads", rd_n, TAPS);
        chk("restart_busy", busy, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check_zero("final_idle");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
